// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 definitions for ps2_host_tx, ps2_host and keyboard_parser.
//   - host-transmit FSM state encoding
//   - keyboard command / response byte constants
//   - odd-parity helper for the host-to-device frame
package ps2_pkg;

  // Keyboard command and response bytes
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_ACK          = 8'hFA;

  // Host-transmit FSM states
  typedef logic [2:0] ps2_state_t;
  localparam ps2_state_t ST_IDLE     = 3'd0;
  localparam ps2_state_t ST_INHIBIT  = 3'd1;
  localparam ps2_state_t ST_REQ      = 3'd2;
  localparam ps2_state_t ST_SHIFT    = 3'd3;
  localparam ps2_state_t ST_ACK      = 3'd4;
  localparam ps2_state_t ST_WAIT_REL = 3'd5;
  localparam ps2_state_t ST_DONE     = 3'd6;
  localparam ps2_state_t ST_ERR      = 3'd7;

  // PS/2 frames carry odd parity: parity bit makes the count of ones odd
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-FF synchronizer plus falling-edge detect for one PS/2 line.
//   clk     : system clock
//   reset   : async active-low reset; all flops come up high (idle line)
//   line_in : raw asynchronous PS/2 line
//   level   : synchronized line level
//   fall    : one-cycle pulse when the synchronized level goes 1 -> 0
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic level,
  output logic fall
);

  // [0] metastability stage, [1] synchronized level, [2] previous level
  logic [2:0] sh;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sh <= 3'b111;
    else        sh <= {sh[1:0], line_in};
  end

  assign level = sh[1];
  assign fall  = sh[2] & ~sh[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter (keyboard commands).
//   clk          : system clock, rising edge
//   reset        : async active-low reset
//   ps2_clk_in   : sampled PS/2 clock line (async)
//   ps2_data_in  : sampled PS/2 data line (async)
//   ps2_clk_oe   : 1 = pull PS/2 clock low, 0 = release
//   ps2_data_oe  : 1 = pull PS/2 data low, 0 = release
//   tx_data      : command byte, captured with tx_start
//   tx_start     : single-cycle request, ignored while busy
//   tx_busy      : high from accepted request until back in IDLE
//   tx_done      : one-cycle pulse, byte sent and ACK seen
//   tx_error     : one-cycle pulse, timeout or missing ACK
// The chip-level pad wrapper builds the open-drain lines from the enables:
//   assign ps2_clk  = ps2_clk_oe  ? 1'b0 : 1'bz;  (external pull-up)
//   assign ps2_data = ps2_data_oe ? 1'b0 : 1'bz;  (external pull-up)
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int INHIBIT_CYCLES = CLK_FREQ_HZ / 100_000 * 12,  // 120 us
  parameter int TIMEOUT_CYCLES = CLK_FREQ_HZ / 50             // 20 ms
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
  // ERR is entered exactly TIMEOUT_CYCLES cycles after the last clearing
  // event (REQ or a clock falling edge): the counter reads 0 one cycle after
  // the clear, so the decision is taken at TIMEOUT_CYCLES-2.
  localparam logic [TMO_W-1:0] TMO_HIT  = TMO_W'(TIMEOUT_CYCLES - 2);

  ps2_state_t       state;
  logic [INH_W-1:0] inh_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [3:0]       bit_cnt;
  logic [9:0]       sh;        // {stop, parity, data[7:0]}, LSB goes out first
  logic             clk_s, clk_fall;
  logic             data_s, data_fall_unused;
  logic             timeout;

  ps2_sync_edge u_clk_sync (
    .clk(clk), .reset(reset), .line_in(ps2_clk_in),
    .level(clk_s), .fall(clk_fall)
  );

  ps2_sync_edge u_data_sync (
    .clk(clk), .reset(reset), .line_in(ps2_data_in),
    .level(data_s), .fall(data_fall_unused)
  );

  assign timeout  = (tmo_cnt == TMO_HIT);
  assign tx_busy  = (state != ST_IDLE);
  assign tx_done  = (state == ST_DONE);
  assign tx_error = (state == ST_ERR);

  // Line enables are registered so the open-drain pads never see decode glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      inh_cnt     <= '0;
      tmo_cnt     <= '0;
      bit_cnt     <= '0;
      sh          <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (tx_start) begin
            sh         <= {1'b1, odd_parity(tx_data), tx_data};
            inh_cnt    <= '0;
            ps2_clk_oe <= 1'b1;
            state      <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          inh_cnt <= inh_cnt + 1'b1;
          // data goes low in the final inhibit cycle, before clock release
          if (inh_cnt == INH_PRE) ps2_data_oe <= 1'b1;
          if (inh_cnt == INH_LAST) begin
            ps2_clk_oe <= 1'b0;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          ps2_data_oe <= 1'b1;   // start bit
          bit_cnt     <= '0;
          tmo_cnt     <= '0;
          state       <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (clk_fall) begin
            tmo_cnt     <= '0;
            bit_cnt     <= bit_cnt + 4'd1;
            ps2_data_oe <= ~sh[0];
            sh          <= {1'b0, sh[9:1]};
            if (bit_cnt == 4'd9) state <= ST_ACK;  // stop bit just driven
          end else if (timeout) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            state       <= ST_ERR;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_ACK: begin
          if (clk_fall) begin
            tmo_cnt <= '0;
            bit_cnt <= 4'd11;
            state   <= data_s ? ST_ERR : ST_WAIT_REL;
          end else if (timeout) begin
            state <= ST_ERR;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_WAIT_REL: begin
          if (clk_fall)              tmo_cnt <= '0;
          else if (clk_s && data_s)  state   <= ST_DONE;
          else if (timeout)          state   <= ST_ERR;
          else                       tmo_cnt <= tmo_cnt + 1'b1;
        end
        ST_DONE: state <= ST_IDLE;
        ST_ERR: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a simple PS/2 device
// model (open-drain lines with pull-up, device clocks 11 edges and ACKs).
// Cycle counts are scaled down so the whole run stays short.
module tb_ps2_host_tx;

  localparam int INH  = 120;
  localparam int TMO  = 1000;
  localparam int HALF = 20;    // device clock half period in system cycles

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy, tx_done, tx_error;

  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;

  // wired-AND with pull-up: either side pulling low wins
  assign ps2_clk_in  = ~(ps2_clk_oe  | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_FREQ_HZ(100_000_000),
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error)
  );

  always @(negedge clk) begin
    if (tx_done)             done_cnt++;
    if (tx_error)            err_cnt++;
    if (tx_done && tx_error) both_cnt++;
  end

`define CHK(tag, obs, exp) \
  begin \
    n_tests++; \
    assert ((obs) === (exp)) else begin \
      n_fail++; \
      $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
    end \
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_tx(input logic [7:0] b);
    tx_data  = b;
    tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
  endtask

  // Counts cycles with the clock inhibited; returns at the first released cycle.
  task automatic inhibit_phase(output int nlow, output logic data_before_rel);
    int g = 0;
    nlow = 0;
    data_before_rel = 1'b0;
    while (!ps2_clk_oe && g < 50) begin tick(1); g++; end
    while (ps2_clk_oe && nlow < 20000) begin
      data_before_rel = ps2_data_oe;
      nlow++;
      tick(1);
    end
  endtask

  // Device clocks 11 falling edges and samples data at each rising edge.
  task automatic device_clock(input logic ack_low, input int inj_edge,
                              input int abort_edge, output logic [9:0] seen);
    seen = '0;
    tick(5);
    `CHK("start_bit", ps2_data_in, 1'b0)
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ack_low) dev_data_low = 1'b1;
      dev_clk_low = 1'b1;
      if (k == abort_edge) begin
        tick(HALF / 2);
        reset = 1'b0;
        #1;
        `CHK("abort_clk_oe",  ps2_clk_oe,  1'b0)
        `CHK("abort_data_oe", ps2_data_oe, 1'b0)
        `CHK("abort_busy",    tx_busy,     1'b0)
        tick(3);
        dev_clk_low = 1'b0;
        tick(3);
        reset = 1'b1;
        return;
      end
      if (k == inj_edge) begin
        tick(2);
        tx_data  = 8'h00;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
        tick(HALF - 3);
      end else begin
        tick(HALF);
      end
      if (k <= 10) seen[k-1] = ps2_data_in;
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      tick(HALF);
    end
  endtask

  initial begin
    int         nlow, d0, e0, cnt;
    logic       dbr;
    logic [9:0] seen;

    reset    = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    tick(3);
    `CHK("rst_clk_oe",  ps2_clk_oe,  1'b0)
    `CHK("rst_data_oe", ps2_data_oe, 1'b0)
    `CHK("rst_busy",    tx_busy,     1'b0)
    `CHK("rst_done",    tx_done,     1'b0)
    `CHK("rst_error",   tx_error,    1'b0)
    reset = 1'b1;
    tick(3);

    // 0xED, ACK: frame {stop=1, parity=1 (six ones), 0xED}
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hED);
    `CHK("ed_busy", tx_busy, 1'b1)
    inhibit_phase(nlow, dbr);
    `CHK("ed_inhibit_len", nlow, INH)
    `CHK("ed_data_before_rel", dbr, 1'b1)
    device_clock(1'b1, 0, 0, seen);
    `CHK("ed_frame", seen, 10'h3ED)
    tick(20);
    `CHK("ed_done_once", done_cnt - d0, 1)
    `CHK("ed_no_err", err_cnt - e0, 0)
    `CHK("ed_busy_after", tx_busy, 1'b0)

    // 0xFF: eight ones -> parity 1
    d0 = done_cnt;
    start_tx(8'hFF);
    inhibit_phase(nlow, dbr);
    `CHK("ff_inhibit_len", nlow, INH)
    `CHK("ff_data_before_rel", dbr, 1'b1)
    device_clock(1'b1, 0, 0, seen);
    `CHK("ff_frame", seen, 10'h3FF)
    tick(20);
    `CHK("ff_done_once", done_cnt - d0, 1)

    // No device clock after release: error exactly TMO cycles later
    e0 = err_cnt; d0 = done_cnt;
    start_tx(8'h55);
    inhibit_phase(nlow, dbr);
    cnt = 0;
    while (!tx_error && cnt < TMO + 50) begin tick(1); cnt++; end
    `CHK("tmo_cycles", cnt, TMO)
    `CHK("tmo_clk_oe", ps2_clk_oe, 1'b0)
    `CHK("tmo_data_oe", ps2_data_oe, 1'b0)
    tick(1);
    `CHK("tmo_busy_after", tx_busy, 1'b0)
    `CHK("tmo_err_once", err_cnt - e0, 1)
    `CHK("tmo_no_done", done_cnt - d0, 0)

    // Device leaves data high on edge 11: missing ACK
    e0 = err_cnt; d0 = done_cnt;
    start_tx(8'hED);
    inhibit_phase(nlow, dbr);
    device_clock(1'b0, 0, 0, seen);
    tick(20);
    `CHK("nack_err_once", err_cnt - e0, 1)
    `CHK("nack_no_done", done_cnt - d0, 0)

    // 0xF4 with a 0x00 request during SHIFT: parity 0 (five ones)
    d0 = done_cnt;
    start_tx(8'hF4);
    inhibit_phase(nlow, dbr);
    device_clock(1'b1, 3, 0, seen);
    `CHK("f4_frame", seen, 10'h2F4)
    tick(20);
    `CHK("f4_done_once", done_cnt - d0, 1)
    `CHK("f4_busy_after", tx_busy, 1'b0)

    // Reset at edge 5, then a clean 0xED
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hED);
    inhibit_phase(nlow, dbr);
    device_clock(1'b1, 0, 5, seen);
    tick(50);
    `CHK("abort_no_done", done_cnt - d0, 0)
    `CHK("abort_no_err", err_cnt - e0, 0)
    `CHK("abort_idle", tx_busy, 1'b0)
    start_tx(8'hED);
    inhibit_phase(nlow, dbr);
    `CHK("re_inhibit_len", nlow, INH)
    device_clock(1'b1, 0, 0, seen);
    `CHK("re_frame", seen, 10'h3ED)
    tick(20);
    `CHK("re_done_once", done_cnt - d0, 1)

    `CHK("done_err_exclusive", both_cnt, 0)

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Backstop against a hung run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100_000_000, system clock frequency.
REQ-002 SHALL have parameter INHIBIT_CYCLES, default 12_000 (120 us at 100 MHz), length of the host clock-low request.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 2_000_000 (20 ms), maximum wait for device clock activity.
REQ-004 SHALL have port clk  input  1  100 MHz system clock; one clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-006 SHALL have port ps2_clk_in  input  1  sampled PS/2 clock line, asynchronous.
REQ-007 SHALL have port ps2_data_in  input  1  sampled PS/2 data line, asynchronous.
REQ-008 SHALL have port ps2_clk_oe  output  1  1 = pull PS/2 clock low; 0 = release (open-drain).
REQ-009 SHALL have port ps2_data_oe  output  1  1 = pull PS/2 data low; 0 = release.
REQ-010 SHALL have port tx_data  input  8  command byte to send to the keyboard (e.g. 0xED, 0xFF).
REQ-011 SHALL have port tx_start  input  1  single-cycle request; tx_data captured on this cycle.
REQ-012 SHALL have port tx_busy  output  1  high from accepted tx_start until return to IDLE.
REQ-013 SHALL have port tx_done  output  1  one-cycle pulse: byte sent and device ACK seen.
REQ-014 SHALL have port tx_error  output  1  one-cycle pulse: timeout or missing ACK.

Function
REQ-015 SHALL pass ps2_clk_in/ps2_data_in through 2-FF synchronizers; falling edge of ps2_clk = sync'd prev 1, current 0.
REQ-016 SHALL implement states IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_REL, DONE, ERR.
REQ-017 IDLE: oe outputs 0, tx_busy 0; tx_start=1 -> latch tx_data, compute odd parity (~^tx_data), go INHIBIT next cycle.
REQ-018 tx_start while tx_busy=1 SHALL be ignored; latched byte unchanged.
REQ-019 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles; ps2_data_oe=1 asserted in the last cycle; then REQ.
REQ-020 REQ: ps2_clk_oe=0, ps2_data_oe=1 (start bit), bit counter=0, timeout counter cleared; go SHIFT.
REQ-021 SHIFT: on each ps2_clk falling edge drive next bit: edges 1-8 = data LSB first, edge 9 = parity, edge 10 = stop (ps2_data_oe=0); ps2_data_oe = ~bit.
REQ-022 After edge 10 SHALL enter ACK; on edge 11 sample ps2_data_in: 0 -> WAIT_REL, 1 -> ERR.
REQ-023 WAIT_REL: wait until sync'd clock and data both high, then DONE.
REQ-024 DONE: tx_done=1 for one cycle, -> IDLE. ERR: tx_error=1 for one cycle, both oe=0, -> IDLE.
REQ-025 Timeout counter SHALL clear on every ps2_clk falling edge in REQ/SHIFT/ACK/WAIT_REL; reaching TIMEOUT_CYCLES -> ERR.
REQ-026 Counter widths SHALL be $clog2 of parameter +1; bit counter 4 bits, saturating at 11.
REQ-027 tx_done and tx_error SHALL never be high together; tx_busy SHALL be low in the cycle after DONE/ERR.

Reset
REQ-028 reset=0 SHALL asynchronously force IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_busy=0, tx_done=0, tx_error=0, counters and synchronizers to idle-high/zero.
REQ-029 reset asserted mid-transfer SHALL release both lines immediately; no tx_done/tx_error after deassertion.

Structure
REQ-030 Package ps2_pkg SHALL hold the state enum and command constants (PS2_CMD_SET_LEDS=0xED, PS2_CMD_RESET=0xFF, PS2_CMD_ENABLE=0xF4, PS2_ACK=0xFA), shared with ps2_host and keyboard_parser.
REQ-031 Sub-module ps2_sync_edge (2-FF synchronizer + falling-edge detect) SHALL be instantiated once per line and be reusable by ps2_host.
REQ-032 Top level SHALL implement open-drain as: line = oe ? 0 : Z, with pull-up.

Verification
REQ-033 tx_data=0xED, device model clocks 11 edges at 12 kHz, ACK low -> data bits 1,0,1,1,0,1,1,1 (LSB first), parity 1... stop 1, tx_done pulse once, tx_busy low after.
REQ-034 tx_data=0xFF -> parity bit 1 (odd), clock held low >=12_000 cycles before release, data low before clock release.
REQ-035 No device clock after REQ -> tx_error pulse at exactly TIMEOUT_CYCLES, both oe=0.
REQ-036 Device leaves data high on edge 11 -> tx_error pulse, no tx_done.
REQ-037 Second tx_start (0x00) during SHIFT of 0xF4 -> ignored; bits on wire still 0xF4.
REQ-038 reset=0 at edge 5 -> both oe=0 same cycle, tx_busy=0; after release, new 0xED transfer completes normally.
